// File: rtl/decode_stage.sv
// Instruction decode stage: field extraction, register read, scoreboard hazard
// detection and a single-entry output register feeding the ALU.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [6:0]  ex_op,
  output logic [31:0] ex_x,
  output logic [31:0] ex_y,
  output logic [31:0] ex_sdata,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_wr_en,
  output logic [31:0] ex_pc,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_SUB  = 7'h02;
  localparam logic [6:0] OP_MUL  = 7'h03;
  localparam logic [6:0] OP_LDB  = 7'h04;
  localparam logic [6:0] OP_LDW  = 7'h05;
  localparam logic [6:0] OP_STB  = 7'h06;
  localparam logic [6:0] OP_STW  = 7'h07;
  localparam logic [6:0] OP_MOV  = 7'h08;
  localparam logic [6:0] OP_BEQ  = 7'h09;
  localparam logic [6:0] OP_JUMP = 7'h0A;
  localparam logic [6:0] OP_TLBW = 7'h0B;
  localparam logic [6:0] OP_IRET = 7'h0C;

  logic [6:0]  op_s;
  logic [4:0]  fa_s, fb_s, fc_s;
  logic [31:0] imm15_s, imm20_s, imm25_s;
  logic        use_a_s, use_b_s;
  logic [31:0] dec_x_s, dec_y_s, dec_sdata_s, dec_imm_s;
  logic [4:0]  dec_rd_s;
  logic        dec_wr_s, dec_wr_en_s, dec_illegal_s;
  logic        hit_a_s, hit_b_s, hazard_s, accept_s, transfer_s;
  logic [31:0] pending_r, clr_mask_s, set_mask_s, pending_next_s;

  assign op_s    = if_instr[31:25];
  assign fa_s    = if_instr[24:20];
  assign fb_s    = if_instr[19:15];
  assign fc_s    = if_instr[14:10];
  assign imm15_s = {{17{if_instr[14]}}, if_instr[14:0]};
  assign imm20_s = {{12{if_instr[19]}}, if_instr[19:0]};
  assign imm25_s = {{7{if_instr[24]}}, if_instr[24:0]};

  // Per-opcode operand selection; fields an opcode does not use stay zero.
  always_comb begin
    rf_raddr_a    = 5'd0;
    rf_raddr_b    = 5'd0;
    use_a_s       = 1'b0;
    use_b_s       = 1'b0;
    dec_x_s       = 32'd0;
    dec_y_s       = 32'd0;
    dec_sdata_s   = 32'd0;
    dec_imm_s     = 32'd0;
    dec_rd_s      = 5'd0;
    dec_wr_s      = 1'b0;
    dec_illegal_s = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB, OP_MUL: begin
        rf_raddr_a = fb_s; rf_raddr_b = fc_s; use_a_s = 1'b1; use_b_s = 1'b1;
        dec_rd_s = fa_s; dec_x_s = rf_rdata_a; dec_y_s = rf_rdata_b; dec_wr_s = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        rf_raddr_a = fb_s; use_a_s = 1'b1;
        dec_rd_s = fa_s; dec_x_s = rf_rdata_a; dec_y_s = imm15_s; dec_wr_s = 1'b1;
      end
      OP_STB, OP_STW: begin
        rf_raddr_a = fb_s; rf_raddr_b = fa_s; use_a_s = 1'b1; use_b_s = 1'b1;
        dec_x_s = rf_rdata_a; dec_y_s = imm15_s; dec_sdata_s = rf_rdata_b;
      end
      OP_MOV: begin
        dec_rd_s = fa_s; dec_x_s = imm20_s; dec_wr_s = 1'b1;
      end
      OP_BEQ: begin
        rf_raddr_a = fa_s; rf_raddr_b = fb_s; use_a_s = 1'b1; use_b_s = 1'b1;
        dec_x_s = rf_rdata_a; dec_y_s = rf_rdata_b; dec_imm_s = imm15_s;
      end
      OP_JUMP: begin
        dec_imm_s = imm25_s;
      end
      OP_TLBW: begin
        rf_raddr_a = fb_s; rf_raddr_b = fc_s; use_a_s = 1'b1; use_b_s = 1'b1;
        dec_x_s = rf_rdata_a; dec_y_s = rf_rdata_b;
      end
      OP_IRET: begin
        dec_wr_s = 1'b0;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  assign dec_wr_en_s = dec_wr_s && (dec_rd_s != 5'd0);

  // A source stalls on the registered mask or on the held entry's destination.
  assign hit_a_s = use_a_s && (rf_raddr_a != 5'd0) &&
                   (pending_r[rf_raddr_a] || (ex_valid && ex_wr_en && (ex_rd == rf_raddr_a)));
  assign hit_b_s = use_b_s && (rf_raddr_b != 5'd0) &&
                   (pending_r[rf_raddr_b] || (ex_valid && ex_wr_en && (ex_rd == rf_raddr_b)));
  assign hazard_s   = hit_a_s || hit_b_s;
  assign id_ready   = !reset && !flush && !hazard_s && (!ex_valid || ex_ready);
  assign accept_s   = if_valid && id_ready;
  assign transfer_s = ex_valid && ex_ready;

  // Set is applied after clear so a same-cycle set of one bit wins.
  assign clr_mask_s     = wb_valid ? (32'd1 << wb_rd) : 32'd0;
  assign set_mask_s     = (transfer_s && ex_wr_en && !flush) ? (32'd1 << ex_rd) : 32'd0;
  assign pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

  // Output register and scoreboard state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= 32'd0;
      ex_valid   <= 1'b0;
      ex_op      <= 7'd0;
      ex_x       <= 32'd0;
      ex_y       <= 32'd0;
      ex_sdata   <= 32'd0;
      ex_imm     <= 32'd0;
      ex_rd      <= 5'd0;
      ex_wr_en   <= 1'b0;
      ex_pc      <= 32'd0;
      ex_illegal <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept_s) begin
        ex_valid   <= 1'b1;
        ex_op      <= op_s;
        ex_x       <= dec_x_s;
        ex_y       <= dec_y_s;
        ex_sdata   <= dec_sdata_s;
        ex_imm     <= dec_imm_s;
        ex_rd      <= dec_rd_s;
        ex_wr_en   <= dec_wr_en_s;
        ex_pc      <= if_pc;
        ex_illegal <= dec_illegal_s;
      end else if (transfer_s) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= ex_valid;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_LDW  = 7'h05;
  localparam logic [6:0] OP_STW  = 7'h07;
  localparam logic [6:0] OP_MOV  = 7'h08;
  localparam logic [6:0] OP_BEQ  = 7'h09;
  localparam logic [6:0] OP_JUMP = 7'h0A;

  logic        clk = 1'b0;
  logic        reset, if_valid, id_ready, wb_valid, flush, ex_valid, ex_ready;
  logic [31:0] if_instr, if_pc, rf_rdata_a, rf_rdata_b;
  logic [4:0]  rf_raddr_a, rf_raddr_b, wb_rd, ex_rd;
  logic [6:0]  ex_op;
  logic [31:0] ex_x, ex_y, ex_sdata, ex_imm, ex_pc;
  logic        ex_wr_en, ex_illegal;
  logic [31:0] regs [0:31];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];

  decode_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_x(ex_x),
    .ex_y(ex_y), .ex_sdata(ex_sdata), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {op, a, b, c, 10'd0};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b, input logic [14:0] imm);
    return {op, a, b, imm};
  endfunction
  function automatic logic [31:0] enc_m(input logic [6:0] op, input logic [4:0] a, input logic [19:0] imm);
    return {op, a, imm};
  endfunction

  task automatic wb_clear(input logic [4:0] rd);
    @(negedge clk); wb_valid = 1'b1; wb_rd = rd;
    @(negedge clk); wb_valid = 1'b0; wb_rd = 5'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", id_ready); end
    total++; if (ex_x !== 32'd0) begin bad++; $display("FAIL reset_x got=%h exp=0", ex_x); end
    total++; if (ex_op !== 7'd0) begin bad++; $display("FAIL reset_op got=%h exp=0", ex_op); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr got=%0b exp=0", ex_wr_en); end
    reset = 1'b0;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", id_ready); end
  endtask

  task automatic test_add;
    @(negedge clk);
    regs[1] = 32'd5; regs[2] = 32'd7;
    if_instr = enc_r(OP_ADD, 5'd3, 5'd1, 5'd2); if_pc = 32'h0000_0100; if_valid = 1'b1; ex_ready = 1'b1;
    #1;
    total++; if (rf_raddr_a !== 5'd1) begin bad++; $display("FAIL add_raddr_a got=%0d exp=1", rf_raddr_a); end
    total++; if (rf_raddr_b !== 5'd2) begin bad++; $display("FAIL add_raddr_b got=%0d exp=2", rf_raddr_b); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%0b exp=1", id_ready); end
    @(negedge clk);
    if_valid = 1'b0; if_instr = 32'd0;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b exp=1", ex_valid); end
    total++; if (ex_op !== OP_ADD) begin bad++; $display("FAIL add_op got=%h exp=%h", ex_op, OP_ADD); end
    total++; if (ex_x !== 32'd5) begin bad++; $display("FAIL add_x got=%h exp=5", ex_x); end
    total++; if (ex_y !== 32'd7) begin bad++; $display("FAIL add_y got=%h exp=7", ex_y); end
    total++; if (ex_rd !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", ex_rd); end
    total++; if (ex_wr_en !== 1'b1) begin bad++; $display("FAIL add_wr got=%0b exp=1", ex_wr_en); end
    total++; if (ex_pc !== 32'h0000_0100) begin bad++; $display("FAIL add_pc got=%h exp=100", ex_pc); end
    total++; if (ex_illegal !== 1'b0) begin bad++; $display("FAIL add_illegal got=%0b exp=0", ex_illegal); end
    @(negedge clk);
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%0b exp=0", ex_valid); end
    if_instr = enc_r(OP_ADD, 5'd8, 5'd3, 5'd0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL add_pending3 got=%0b exp=0", id_ready); end
    if_instr = 32'd0;
    wb_clear(5'd3);
  endtask

  task automatic test_load_hazard;
    @(negedge clk);
    regs[4] = 32'd9;
    if_instr = enc_i(OP_LDW, 5'd4, 5'd1, 15'd8); if_valid = 1'b1;
    @(negedge clk);
    total++; if (ex_rd !== 5'd4) begin bad++; $display("FAIL ldw_rd got=%0d exp=4", ex_rd); end
    total++; if (ex_y !== 32'd8) begin bad++; $display("FAIL ldw_y got=%h exp=8", ex_y); end
    if_instr = enc_r(OP_ADD, 5'd7, 5'd4, 5'd2);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL haz_held got=%0b exp=0", id_ready); end
    @(negedge clk); #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL haz_pending got=%0b exp=0", id_ready); end
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd4;
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL haz_no_bypass got=%0b exp=0", id_ready); end
    @(negedge clk);
    wb_valid = 1'b0; wb_rd = 5'd0;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL haz_released got=%0b exp=1", id_ready); end
    @(negedge clk);
    if_valid = 1'b0; if_instr = 32'd0;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL haz_accept got=%0b exp=1", ex_valid); end
    total++; if (ex_rd !== 5'd7) begin bad++; $display("FAIL haz_rd got=%0d exp=7", ex_rd); end
    total++; if (ex_x !== 32'd9) begin bad++; $display("FAIL haz_x got=%h exp=9", ex_x); end
    wb_clear(5'd7);
  endtask

  task automatic test_store;
    @(negedge clk);
    regs[2] = 32'h0000_0100; regs[6] = 32'h0000_00AB;
    if_instr = enc_i(OP_STW, 5'd6, 5'd2, 15'h7FFF); if_valid = 1'b1;
    #1;
    total++; if (rf_raddr_b !== 5'd6) begin bad++; $display("FAIL st_raddr_b got=%0d exp=6", rf_raddr_b); end
    @(negedge clk);
    if_valid = 1'b0; if_instr = 32'd0;
    total++; if (ex_x !== 32'h0000_0100) begin bad++; $display("FAIL st_x got=%h exp=100", ex_x); end
    total++; if (ex_y !== 32'hFFFF_FFFF) begin bad++; $display("FAIL st_y got=%h exp=ffffffff", ex_y); end
    total++; if (ex_sdata !== 32'h0000_00AB) begin bad++; $display("FAIL st_sdata got=%h exp=ab", ex_sdata); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL st_wr got=%0b exp=0", ex_wr_en); end
    total++; if (ex_rd !== 5'd0) begin bad++; $display("FAIL st_rd got=%0d exp=0", ex_rd); end
  endtask

  task automatic test_stall_flush;
    @(negedge clk);
    ex_ready = 1'b0;
    if_instr = enc_m(OP_MOV, 5'd5, 20'h80000); if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_instr = enc_r(OP_ADD, 5'd8, 5'd1, 5'd2);
      #1;
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%0b exp=1", i, ex_valid); end
      total++; if (ex_x !== 32'hFFF8_0000) begin bad++; $display("FAIL stall_x[%0d] got=%h exp=fff80000", i, ex_x); end
      total++; if (ex_rd !== 5'd5) begin bad++; $display("FAIL stall_rd[%0d] got=%0d exp=5", i, ex_rd); end
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%0b exp=0", i, id_ready); end
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    if_instr = enc_r(OP_ADD, 5'd8, 5'd5, 5'd0);
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", ex_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_pending5 got=%0b exp=1", id_ready); end
    @(negedge clk);
    flush = 1'b1; if_valid = 1'b1; if_instr = enc_m(OP_MOV, 5'd13, 20'd1);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", id_ready); end
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0; if_instr = 32'd0;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_noaccept got=%0b exp=0", ex_valid); end
  endtask

  task automatic test_illegal;
    logic [31:0] bad_instr;
    bad_instr = {7'h7F, 25'h1ABCDEF};
    @(negedge clk);
    if_instr = bad_instr; if_valid = 1'b1;
    @(negedge clk);
    if_instr = enc_m(OP_MOV, 5'd0, 20'd5);
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL ill_valid got=%0b exp=1", ex_valid); end
    total++; if (ex_op !== 7'h7F) begin bad++; $display("FAIL ill_op got=%h exp=7f", ex_op); end
    total++; if (ex_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%0b exp=1", ex_illegal); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL ill_wr got=%0b exp=0", ex_wr_en); end
    total++; if ({ex_x, ex_y, ex_sdata, ex_imm} !== 128'd0) begin bad++; $display("FAIL ill_data got=%h/%h/%h/%h exp=0", ex_x, ex_y, ex_sdata, ex_imm); end
    @(negedge clk);
    if_valid = 1'b0; if_instr = enc_r(OP_ADD, 5'd1, 5'd0, 5'd0);
    total++; if (ex_x !== 32'd5) begin bad++; $display("FAIL mov0_x got=%h exp=5", ex_x); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL mov0_wr got=%0b exp=0", ex_wr_en); end
    total++; if (ex_illegal !== 1'b0) begin bad++; $display("FAIL mov0_illegal got=%0b exp=0", ex_illegal); end
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL src0_held got=%0b exp=1", id_ready); end
    @(negedge clk); #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL src0_after got=%0b exp=1", id_ready); end
    if_instr = 32'd0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = enc_m(OP_MOV, 5'd10, 20'd1);
    @(negedge clk);
    if_instr = enc_m(OP_MOV, 5'd11, 20'd2);
    total++; if (ex_rd !== 5'd10 || ex_x !== 32'd1) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=10/1", ex_rd, ex_x); end
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", id_ready); end
    @(negedge clk);
    if_instr = enc_i(OP_BEQ, 5'd1, 5'd2, 15'h4000);
    total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd11 || ex_x !== 32'd2) begin bad++; $display("FAIL b2b_second got=%0b/%0d/%h exp=1/11/2", ex_valid, ex_rd, ex_x); end
    @(negedge clk);
    if_instr = {OP_JUMP, 25'h1000000};
    total++; if (ex_op !== OP_BEQ) begin bad++; $display("FAIL beq_op got=%h exp=%h", ex_op, OP_BEQ); end
    total++; if (ex_x !== 32'd5 || ex_y !== 32'h0000_0100) begin bad++; $display("FAIL beq_xy got=%h/%h exp=5/100", ex_x, ex_y); end
    total++; if (ex_imm !== 32'hFFFF_C000) begin bad++; $display("FAIL beq_imm got=%h exp=ffffc000", ex_imm); end
    total++; if (ex_wr_en !== 1'b0) begin bad++; $display("FAIL beq_wr got=%0b exp=0", ex_wr_en); end
    @(negedge clk);
    if_valid = 1'b0; if_instr = 32'd0;
    total++; if (ex_imm !== 32'hFF00_0000) begin bad++; $display("FAIL jump_imm got=%h exp=ff000000", ex_imm); end
    total++; if (ex_x !== 32'd0) begin bad++; $display("FAIL jump_x got=%h exp=0", ex_x); end
    @(negedge clk);
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b exp=0", ex_valid); end
    wb_clear(5'd10);
    wb_clear(5'd11);
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = enc_m(OP_MOV, 5'd12, 20'd3);
    @(negedge clk);
    if_instr = enc_i(OP_LDW, 5'd9, 5'd1, 15'd0);
    @(negedge clk);
    ex_ready = 1'b0; if_valid = 1'b0; if_instr = enc_r(OP_ADD, 5'd8, 5'd12, 5'd9);
    total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin bad++; $display("FAIL mid_held got=%0b/%0d exp=1/9", ex_valid, ex_rd); end
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL mid_stall got=%0b exp=0", id_ready); end
    reset = 1'b1;
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%0b exp=0", id_ready); end
    @(negedge clk);
    reset = 1'b0; ex_ready = 1'b1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", ex_valid); end
    total++; if (ex_x !== 32'd0 || ex_rd !== 5'd0) begin bad++; $display("FAIL mid_data got=%h/%0d exp=0/0", ex_x, ex_rd); end
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL mid_resume got=%0b exp=1", id_ready); end
    if_instr = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0; ex_ready = 1'b0;
    test_reset();
    test_add();
    test_load_hazard();
    test_store();
    test_stall_flush();
    test_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
